// File: rtl/crc_arb_pkg.sv
// Shared constants and helpers for the CRC checker arbiter.
package crc_arb_pkg;

   localparam int unsigned DATA_W_DEF = 32;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_GNT  = 1'b1;

   // Bits needed to hold an index in [0, n-1]; never less than one.
   function automatic int unsigned id_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/crc_arb_tag_fifo.sv
// Small synchronous FIFO holding the owner id of each packet inside the checker.
module crc_arb_tag_fifo
   import crc_arb_pkg::*;
#(
   parameter int unsigned WIDTH = 2,
   parameter int unsigned DEPTH = 4
) (
   input  logic             iClk,
   input  logic             iRst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic             o_full,
   output logic             o_empty,
   output logic [WIDTH-1:0] o_head
);

   localparam int unsigned AW = id_w(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_cnt;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_cnt == (AW+1)'(DEPTH));
   assign o_empty = (r_cnt == '0);
   assign o_head  = r_mem[r_rptr];

   // A pop frees the slot in the same cycle, so push is allowed when full and popping.
   assign w_push = i_push & (~o_full | i_pop);
   assign w_pop  = i_pop & ~o_empty;

   always_ff @(posedge iClk) begin
      if (w_push) r_mem[r_wptr] <= i_din;
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) r_wptr <= (r_wptr == AW'(DEPTH-1)) ? '0 : r_wptr + AW'(1);
         if (w_pop)  r_rptr <= (r_rptr == AW'(DEPTH-1)) ? '0 : r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
            2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/crc_check_arb.sv
// Round-robin arbiter sharing one CRC checker between N_REQ packet readers,
// with a tag FIFO so each checker verdict is reported against its owner.
module crc_check_arb
   import crc_arb_pkg::*;
#(
   parameter int unsigned N_REQ     = 4,
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned TAG_DEPTH = 4
) (
   input  logic                    iClk,
   input  logic                    iRst_n,
   input  logic [N_REQ-1:0]        iReq,
   output logic [N_REQ-1:0]        oGnt,
   input  logic [N_REQ-1:0]        iReqSop,
   input  logic [N_REQ-1:0]        iReqEop,
   input  logic [N_REQ-1:0]        iReqVld,
   input  logic [N_REQ-1:0]        iReqLast,
   input  logic [N_REQ*DATA_W-1:0] iReqData,
   output logic [N_REQ-1:0]        oReqReady,
   output logic                    oChkSop,
   output logic                    oChkEop,
   output logic                    oChkVld,
   output logic                    oChkLast,
   output logic [DATA_W-1:0]       oChkData,
   input  logic                    iChkReady,
   input  logic                    iChkEop,
   input  logic                    iChkErr,
   output logic                    oDoneVld,
   output logic [id_w(N_REQ)-1:0]  oDonePort,
   output logic                    oDoneErr,
   output logic                    oProtoErr
);

   localparam int unsigned PW = id_w(N_REQ);

   logic [0:0]       r_state;
   logic [0:0]       w_state_nxt;
   logic [N_REQ-1:0] r_gnt;
   logic [N_REQ-1:0] w_gnt_nxt;
   logic [PW-1:0]    r_id;
   logic [PW-1:0]    w_id_nxt;
   logic [PW-1:0]    r_rr_ptr;
   logic [PW-1:0]    w_rr_nxt;
   logic             r_done_vld;
   logic [PW-1:0]    r_done_port;
   logic             r_done_err;
   logic             r_proto_err;
   logic             w_found;
   logic [PW-1:0]    w_win;
   logic [PW-1:0]    w_idx;
   logic             w_fifo_full;
   logic             w_fifo_empty;
   logic [PW-1:0]    w_head;

   assign oGnt      = r_gnt;
   assign oDoneVld  = r_done_vld;
   assign oDonePort = r_done_port;
   assign oDoneErr  = r_done_err;
   assign oProtoErr = r_proto_err;

   // Datapath mux follows the registered one-hot grant.
   assign oChkSop   = |(iReqSop & r_gnt);
   assign oChkEop   = |(iReqEop & r_gnt);
   assign oChkVld   = |(iReqVld & r_gnt);
   assign oChkLast  = |(iReqLast & r_gnt);
   assign oReqReady = {N_REQ{iChkReady}} & r_gnt;

   always_comb begin
      oChkData = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (r_gnt[i]) oChkData = oChkData | iReqData[i*DATA_W +: DATA_W];
      end
   end

   // First pending requester at or above rr_ptr, wrapping at N_REQ.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         w_idx = PW'((32'(r_rr_ptr) + k) % N_REQ);
         if (!w_found && iReq[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_id_nxt    = r_id;
      w_rr_nxt    = r_rr_ptr;
      case (r_state)
         ST_IDLE: begin
            if (w_found && !w_fifo_full) begin
               w_state_nxt = ST_GNT;
               w_gnt_nxt   = N_REQ'(1) << w_win;
               w_id_nxt    = w_win;
            end
         end
         ST_GNT: begin
            if (oChkEop) begin
               w_state_nxt = ST_IDLE;
               w_gnt_nxt   = '0;
               w_rr_nxt    = (r_id == PW'(N_REQ-1)) ? '0 : r_id + PW'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         r_state  <= ST_IDLE;
         r_gnt    <= '0;
         r_id     <= '0;
         r_rr_ptr <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_gnt    <= w_gnt_nxt;
         r_id     <= w_id_nxt;
         r_rr_ptr <= w_rr_nxt;
      end
   end

   crc_arb_tag_fifo #(
      .WIDTH (PW),
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .iClk    (iClk),
      .iRst_n  (iRst_n),
      .i_push  (oChkSop),
      .i_din   (r_id),
      .i_pop   (iChkEop),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_head  (w_head)
   );

   // Verdict is attributed to the oldest tag; an Eop with no tag is a protocol error.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         r_done_vld  <= 1'b0;
         r_done_port <= '0;
         r_done_err  <= 1'b0;
         r_proto_err <= 1'b0;
      end else begin
         r_done_vld <= iChkEop & ~w_fifo_empty;
         if (iChkEop && !w_fifo_empty) begin
            r_done_port <= w_head;
            r_done_err  <= iChkErr;
         end
         if (iChkEop && w_fifo_empty) r_proto_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_crc_check_arb.sv
// Directed self-checking bench for crc_check_arb; the bench plays the checker.
module tb_crc_check_arb;

   logic         iClk;
   logic         iRst_n;
   logic [3:0]   iReq;
   logic [3:0]   oGnt;
   logic [3:0]   iReqSop, iReqEop, iReqVld, iReqLast;
   logic [127:0] iReqData;
   logic [3:0]   oReqReady;
   logic         oChkSop, oChkEop, oChkVld, oChkLast;
   logic [31:0]  oChkData;
   logic         iChkReady, iChkEop, iChkErr;
   logic         oDoneVld;
   logic [1:0]   oDonePort;
   logic         oDoneErr;
   logic         oProtoErr;

   int n_vec = 0;
   int n_err = 0;

   crc_check_arb #(
      .N_REQ     (4),
      .DATA_W    (32),
      .TAG_DEPTH (4)
   ) dut (
      .iClk      (iClk),
      .iRst_n    (iRst_n),
      .iReq      (iReq),
      .oGnt      (oGnt),
      .iReqSop   (iReqSop),
      .iReqEop   (iReqEop),
      .iReqVld   (iReqVld),
      .iReqLast  (iReqLast),
      .iReqData  (iReqData),
      .oReqReady (oReqReady),
      .oChkSop   (oChkSop),
      .oChkEop   (oChkEop),
      .oChkVld   (oChkVld),
      .oChkLast  (oChkLast),
      .oChkData  (oChkData),
      .iChkReady (iChkReady),
      .iChkEop   (iChkEop),
      .iChkErr   (iChkErr),
      .oDoneVld  (oDoneVld),
      .oDonePort (oDonePort),
      .oDoneErr  (oDoneErr),
      .oProtoErr (oProtoErr)
   );

   initial begin
      iClk = 1'b0;
      forever #5 iClk = ~iClk;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   // Granted requester p sends Sop, n words (last word carries the CRC), Eop.
   task automatic send_pkt(input int p, input int n, input logic [31:0] base,
                           input logic corrupt, input logic pop_sop, input int pop_port);
      logic [3:0]  g;
      logic [31:0] d;
      logic        rdy;
      g = 4'(1 << p);
      iReqSop[p] = 1'b1;
      iChkReady  = 1'b1;
      if (pop_sop) iChkEop = 1'b1;
      #1;
      chk("pkt_gnt", 32'(oGnt), 32'(g));
      chk("pkt_sop", 32'(oChkSop), 32'd1);
      chk("pkt_sop_vld", 32'(oChkVld), 32'd0);
      tick();
      iReqSop[p] = 1'b0;
      iChkEop    = 1'b0;
      if (pop_sop) begin
         chk("pop_done_vld", 32'(oDoneVld), 32'd1);
         chk("pop_done_port", 32'(oDonePort), 32'(pop_port));
      end
      for (int w = 0; w < n; w++) begin
         d = base + 32'(w) + ((corrupt && w == n-1) ? 32'd1 : 32'd0);
         iReqVld[p]  = 1'b1;
         iReqLast[p] = (w == n-1);
         iReqData[p*32 +: 32] = d;
         for (int t = 0; t < 8; t++) begin
            rdy = (t == 7) ? 1'b1 : 1'($urandom_range(0, 1));
            iChkReady = rdy;
            #1;
            chk("word_data", oChkData, d);
            chk("word_vld", 32'(oChkVld), 32'd1);
            chk("word_last", 32'(oChkLast), (w == n-1) ? 32'd1 : 32'd0);
            chk("word_ready", 32'(oReqReady), rdy ? 32'(g) : 32'd0);
            tick();
            if (rdy) break;
         end
      end
      iReqVld[p]  = 1'b0;
      iReqLast[p] = 1'b0;
      iReqEop[p]  = 1'b1;
      #1;
      chk("pkt_eop", 32'(oChkEop), 32'd1);
      tick();
      iReqEop[p] = 1'b0;
      chk("pkt_gnt_off", 32'(oGnt), 32'd0);
   endtask

   task automatic chk_eop(input logic err, input int exp_port);
      iChkEop = 1'b1;
      iChkErr = err;
      tick();
      iChkEop = 1'b0;
      iChkErr = 1'b0;
      chk("done_vld", 32'(oDoneVld), 32'd1);
      chk("done_port", 32'(oDonePort), 32'(exp_port));
      chk("done_err", 32'(oDoneErr), 32'(err));
      tick();
      chk("done_pulse", 32'(oDoneVld), 32'd0);
   endtask

   initial begin
      iRst_n = 1'b0;
      iReq = '0; iReqSop = '0; iReqEop = '0; iReqVld = '0; iReqLast = '0;
      iReqData = '0; iChkReady = 1'b1; iChkEop = 1'b0; iChkErr = 1'b0;
      #1;
      chk("rst_gnt", 32'(oGnt), 32'd0);
      chk("rst_ready", 32'(oReqReady), 32'd0);
      chk("rst_chk_vld", 32'(oChkVld), 32'd0);
      chk("rst_done", 32'(oDoneVld), 32'd0);
      chk("rst_port", 32'(oDonePort), 32'd0);
      chk("rst_err", 32'(oDoneErr), 32'd0);
      chk("rst_proto", 32'(oProtoErr), 32'd0);
      tick();
      tick();
      iRst_n = 1'b1;

      // Single requester; req3 drives junk that must be ignored.
      iReqVld[3] = 1'b1;
      iReqData[96 +: 32] = 32'hDEAD_BEEF;
      iReq = 4'b0001;
      tick();
      chk("single_gnt", 32'(oGnt), 32'h1);
      iReq = 4'b0000;
      send_pkt(0, 17, 32'h0000_1000, 1'b0, 1'b0, 0);
      chk_eop(1'b0, 0);
      iReq = 4'b0001;
      tick();
      chk("single_gnt2", 32'(oGnt), 32'h1);
      iReq = 4'b0000;
      send_pkt(0, 17, 32'h0000_2000, 1'b1, 1'b0, 0);
      chk_eop(1'b1, 0);
      iReqVld[3] = 1'b0;
      iReqData   = '0;

      iRst_n = 1'b0;
      tick();
      iRst_n = 1'b1;

      // Fairness until the tag FIFO fills.
      iReq = 4'b1111;
      for (int p = 0; p < 4; p++) begin
         tick();
         chk("fair_gnt", 32'(oGnt), 32'(1 << p));
         send_pkt(p, 2, 32'(p) << 8, 1'b0, 1'b0, 0);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("full_stall", 32'(oGnt), 32'd0);
      end
      iChkEop = 1'b1;
      tick();
      iChkEop = 1'b0;
      chk("full_pop_vld", 32'(oDoneVld), 32'd1);
      chk("full_pop_port", 32'(oDonePort), 32'd0);
      chk("full_gnt_t1", 32'(oGnt), 32'd0);
      tick();
      chk("full_gnt_t2", 32'(oGnt), 32'h1);
      iReq = 4'b0000;
      send_pkt(0, 2, 32'h0000_5000, 1'b0, 1'b1, 1);
      tick();
      chk("idle_no_req", 32'(oGnt), 32'd0);
      chk_eop(1'b0, 2);
      chk_eop(1'b1, 3);
      chk_eop(1'b0, 0);
      iChkEop = 1'b1;
      tick();
      iChkEop = 1'b0;
      chk("spurious_proto", 32'(oProtoErr), 32'd1);
      chk("spurious_no_done", 32'(oDoneVld), 32'd0);
      tick();
      chk("proto_sticky", 32'(oProtoErr), 32'd1);

      // Wrap-around with rr_ptr at 2.
      iReq = 4'b0010;
      tick();
      chk("wrap_pre_gnt", 32'(oGnt), 32'h2);
      iReq = 4'b0000;
      send_pkt(1, 1, 32'h0000_6000, 1'b0, 1'b0, 0);
      iReq = 4'b1010;
      tick();
      chk("wrap_gnt3", 32'(oGnt), 32'h8);
      iReq = 4'b0010;
      send_pkt(3, 1, 32'h0000_7000, 1'b0, 1'b0, 0);
      tick();
      chk("wrap_gnt1", 32'(oGnt), 32'h2);
      iReq = 4'b0000;
      send_pkt(1, 1, 32'h0000_8000, 1'b0, 1'b0, 0);

      // Reset in the middle of a req2 packet.
      iReq = 4'b0100;
      tick();
      chk("mid_gnt2", 32'(oGnt), 32'h4);
      iReqSop[2] = 1'b1;
      tick();
      iReqSop[2] = 1'b0;
      for (int w = 0; w < 5; w++) begin
         iReqVld[2] = 1'b1;
         iReqData[64 +: 32] = 32'h0000_9000 + 32'(w);
         tick();
      end
      #2;
      iRst_n = 1'b0;
      #1;
      chk("mid_rst_gnt", 32'(oGnt), 32'd0);
      chk("mid_rst_vld", 32'(oChkVld), 32'd0);
      chk("mid_rst_data", oChkData, 32'd0);
      chk("mid_rst_ready", 32'(oReqReady), 32'd0);
      chk("mid_rst_proto", 32'(oProtoErr), 32'd0);
      chk("mid_rst_done", 32'(oDoneVld), 32'd0);
      iReqVld = '0;
      iReqData = '0;
      iReq = 4'b0110;
      tick();
      chk("rst_hold_gnt", 32'(oGnt), 32'd0);
      iRst_n = 1'b1;
      tick();
      chk("post_rst_gnt", 32'(oGnt), 32'h2);
      iReq = 4'b0000;
      iChkEop = 1'b1;
      tick();
      iChkEop = 1'b0;
      chk("post_rst_fifo_empty", 32'(oProtoErr), 32'd1);
      chk("post_rst_no_done", 32'(oDoneVld), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
